// File: rtl/game_timer_bcd.sv
// BCD countdown game timer with presets, start/pause/resume, expiry pulse and per-digit 7-segment drive.
// Latency: bcd_out is valid one cycle after load; the first decrement comes CLK_DIV cycles after start.
// No backpressure. Define AUTO_RELOAD_EN to reload the latched preset on expiry instead of holding 0 in DONE.
module game_timer_bcd #(
    parameter int          CLK_DIV = 50000000,
    parameter int          DIGITS  = 3,
    parameter logic [23:0] PRESET0 = 24'h120,
    parameter logic [23:0] PRESET1 = 24'h060,
    parameter logic [23:0] PRESET2 = 24'h030,
    parameter logic [23:0] PRESET3 = 24'h120
) (
    input  logic                  CLOCK_50,
    input  logic                  reset_n,
    input  logic                  load,
    input  logic [1:0]            sel,
    input  logic                  start,
    input  logic                  pause,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [7*DIGITS-1:0]   seg_out,
    output logic                  running,
    output logic                  done,
    output logic                  expired
);

    localparam int W  = 4 * DIGITS;
    localparam int PW = $clog2(CLK_DIV);

    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);
    localparam logic [W-1:0]  COUNT_ONE = W'(1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_PAUSED = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    function automatic bit is_bcd(input logic [23:0] v);
        bit ok;
        ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) ok = 1'b0;
        end
        return ok;
    endfunction

    generate
        if (!(is_bcd(PRESET0) && is_bcd(PRESET1) && is_bcd(PRESET2) && is_bcd(PRESET3))) begin : g_bad_preset
            $error("game_timer_bcd: preset contains a non-BCD digit");
        end
    endgenerate

    function automatic logic [W-1:0] preset_of(input logic [1:0] s);
        logic [W-1:0] p;
        case (s)
            2'd0:    p = PRESET0[W-1:0];
            2'd1:    p = PRESET1[W-1:0];
            2'd2:    p = PRESET2[W-1:0];
            default: p = PRESET3[W-1:0];
        endcase
        return p;
    endfunction

    // Borrow enters digit 0 and ripples while digits are 0.
    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (borrow) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b100_0000;
            4'd1:    s = 7'b111_1001;
            4'd2:    s = 7'b010_0100;
            4'd3:    s = 7'b011_0000;
            4'd4:    s = 7'b001_1001;
            4'd5:    s = 7'b001_0010;
            4'd6:    s = 7'b000_0010;
            4'd7:    s = 7'b111_1000;
            4'd8:    s = 7'b000_0000;
            4'd9:    s = 7'b001_0000;
            default: s = 7'b111_1111;
        endcase
        return s;
    endfunction

    logic [1:0]    state;
    logic [W-1:0]  count;
    logic [PW-1:0] presc;
    logic [1:0]    sel_q;

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            count   <= '0;
            presc   <= '0;
            sel_q   <= 2'd0;
            expired <= 1'b0;
        end else begin
            expired <= 1'b0;
            if (load) begin
                count <= preset_of(sel);
                sel_q <= sel;
                presc <= '0;
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (!pause && start && count != '0) begin
                            state <= ST_RUN;
                            presc <= '0;
                        end
                    end
                    ST_RUN: begin
                        if (pause) begin
                            state <= ST_PAUSED;
                        end else if (presc == PRESC_MAX) begin
                            presc <= '0;
                            if (count == COUNT_ONE) begin
                                expired <= 1'b1;
`ifdef AUTO_RELOAD_EN
                                count   <= preset_of(sel_q);
`else
                                count   <= '0;
                                state   <= ST_DONE;
`endif
                            end else begin
                                count <= bcd_dec(count);
                            end
                        end else begin
                            presc <= presc + 1'b1;
                        end
                    end
                    ST_PAUSED: begin
                        if (start && !pause) state <= ST_RUN;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        seg_out = '1;
        for (int i = 0; i < DIGITS; i++) begin
            seg_out[7*i +: 7] = seg7(count[4*i +: 4]);
        end
    end

    assign bcd_out = count;
    assign running = (state == ST_RUN);
    assign done    = (state == ST_DONE);

endmodule
